// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU multi-cycle sequencer: function codes and FSM state encoding.
package alu_seq_pkg;

    localparam logic [5:0] FN_DIV       = 6'b011010;
    localparam logic [5:0] FN_DIVU      = 6'b011011;
    localparam logic [5:0] FN_MULT      = 6'b011000;
    localparam logic [5:0] FN_MULTU     = 6'b011001;
    localparam logic [5:0] FN_HILO_OPEN = 6'b111111;
    localparam logic [5:0] FN_NOP       = 6'b000000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_RUN    = ST_RUN,
        S_COMMIT = ST_COMMIT
    } state_e;

endpackage

// File: rtl/alu_seq_counter.sv
// Loadable up-counter with a terminal compare against a target latency.
// Clears itself whenever it is neither loaded nor incremented.
module alu_seq_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] target_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load starts at 1, increment while running, otherwise idle at 0.
    always_comb begin
        cnt_d = '0;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == target_i);

endmodule

// File: rtl/alu_multicycle_seq.sv
// ALU control stage: one-cycle function-code register plus a sequencer for
// multi-cycle HI/LO operations. Stalls the pipeline while an op runs, then
// presents the HI/LO-open code with hilo_we for exactly one cycle.
// Define ALU_SEQ_MULT_EN to sequence MULT/MULTU with MULT_CYCLES; otherwise
// they pass through as single-cycle codes.
//
// state  | meaning
// IDLE   | pass inSignal through each cycle, watch for a multi-cycle op
// RUN    | op latched, counting execute cycles, stall asserted
// COMMIT | HI/LO open code + hilo_we for one cycle, flush ignored
module alu_multicycle_seq
    import alu_seq_pkg::*;
#(
    parameter int FUNC_W      = 6,
    parameter int DIV_CYCLES  = 32,
    parameter int MULT_CYCLES = 32,
    parameter int CNT_W       = $clog2(((DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES) + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FUNC_W-1:0] inSignal,
    input  logic              start,
    input  logic              flush,
    output logic [FUNC_W-1:0] outSignal,
    output logic              stall,
    output logic              hilo_we,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [FUNC_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]  lat_tgt;
    logic              is_div, is_multi, accept;
    logic              cnt_inc, cnt_hit;

    assign is_div = (inSignal == FUNC_W'(FN_DIV)) || (inSignal == FUNC_W'(FN_DIVU));

`ifdef ALU_SEQ_MULT_EN
    logic             is_mult;
    logic [CNT_W-1:0] lat_q;

    assign is_mult  = (inSignal == FUNC_W'(FN_MULT)) || (inSignal == FUNC_W'(FN_MULTU));
    assign is_multi = is_div || is_mult;

    // Target latency is captured at accept since inSignal may change afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q <= '0;
        end else if (accept) begin
            lat_q <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
    end

    assign lat_tgt = lat_q;
`else
    assign is_multi = is_div;
    assign lat_tgt  = CNT_W'(DIV_CYCLES);
`endif

    // Simultaneous start and flush drops the start; the code just passes through.
    assign accept = (state_q == S_IDLE) && start && !flush && is_multi;

    alu_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .inc_i    (cnt_inc),
        .target_i (lat_tgt),
        .hit_o    (cnt_hit)
    );

    // Next state and next function code.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                out_d = inSignal;
                if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    out_d   = FUNC_W'(FN_NOP);
                end else if (cnt_hit) begin
                    state_d = S_COMMIT;
                    out_d   = FUNC_W'(FN_HILO_OPEN);
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                out_d   = FUNC_W'(FN_NOP);
            end
            default: begin
                state_d = S_IDLE;
                out_d   = FUNC_W'(FN_NOP);
            end
        endcase
    end

    // State and output-code registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign outSignal = out_q;
    assign stall     = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign hilo_we   = (state_q == S_COMMIT);

endmodule

// File: tb/tb_alu_multicycle_seq.sv
// Self-checking bench for alu_multicycle_seq (DIV_CYCLES=32, MULT_CYCLES=4).
// Expected behaviour is an output waveform built per operation from the
// sequencing rules: LAT cycles of the op with stall, one commit cycle, idle.
module tb_alu_multicycle_seq;

    localparam int DIV_LAT  = 32;
    localparam int MULT_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] inSignal;
    logic       start;
    logic       flush;
    logic [5:0] outSignal;
    logic       stall;
    logic       hilo_we;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [5:0] o;
        logic       s;
        logic       w;
        logic       chk_o;
    } exp_t;

    alu_multicycle_seq #(
        .FUNC_W      (6),
        .DIV_CYCLES  (DIV_LAT),
        .MULT_CYCLES (MULT_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inSignal  (inSignal),
        .start     (start),
        .flush     (flush),
        .outSignal (outSignal),
        .stall     (stall),
        .hilo_we   (hilo_we),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency of a code under the sequencing rules; 0 means single-cycle.
    function automatic int lat_of(input logic [5:0] c);
        if (c == 6'b011010 || c == 6'b011011) return DIV_LAT;
`ifdef ALU_SEQ_MULT_EN
        if (c == 6'b011000 || c == 6'b011001) return MULT_LAT;
`endif
        return 0;
    endfunction

    // Issue one code and compare every cycle against the expected waveform.
    // flush_at: edge index (after accept) carrying flush, 0 = none.
    task automatic do_op(input string name, input logic [5:0] code, input int flush_at,
                         input bit commit_flush, input bit start_flush, input bit start_noise);
        exp_t q[$];
        int   lat;
        lat = start_flush ? 0 : lat_of(code);
        if (lat == 0) begin
            q.push_back('{code, 1'b0, 1'b0, 1'b1});
        end else if (flush_at > 0 && flush_at < lat) begin
            for (int k = 0; k < flush_at; k++) q.push_back('{code, 1'b1, 1'b0, 1'b1});
            q.push_back('{6'h00, 1'b0, 1'b0, 1'b1});
        end else begin
            for (int k = 0; k < lat; k++) q.push_back('{code, 1'b1, 1'b0, 1'b1});
            q.push_back('{6'h3f, 1'b1, 1'b1, 1'b1});
            q.push_back('{6'h00, 1'b0, 1'b0, 1'b0});
        end
        inSignal = code;
        start    = 1'b1;
        flush    = start_flush;
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0) begin
                flush = (lat > 0) && ((k == flush_at) || (commit_flush && k == lat + 1));
                start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            tick();
            if (q[k].chk_o) chk($sformatf("%s[%0d].out", name, k), outSignal, q[k].o);
            chk($sformatf("%s[%0d].stall", name, k), {5'b0, stall}, {5'b0, q[k].s});
            chk($sformatf("%s[%0d].busy", name, k), {5'b0, busy}, {5'b0, q[k].s});
            chk($sformatf("%s[%0d].we", name, k), {5'b0, hilo_we}, {5'b0, q[k].w});
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        logic [5:0] code;
        int         f;
        rst      = 1'b1;
        inSignal = 6'h00;
        start    = 1'b0;
        flush    = 1'b0;
        #12;
        chk("reset.out", outSignal, 6'h00);
        chk("reset.stall", {5'b0, stall}, 6'h00);
        chk("reset.busy", {5'b0, busy}, 6'h00);
        chk("reset.we", {5'b0, hilo_we}, 6'h00);
        rst = 1'b0;
        tick();

        do_op("add", 6'b100000, 0, 1'b0, 1'b0, 1'b0);
        do_op("divu", 6'b011011, 0, 1'b0, 1'b0, 1'b1);
        do_op("div_flush10", 6'b011010, 10, 1'b0, 1'b0, 1'b0);
        do_op("divu_cflush", 6'b011011, 0, 1'b1, 1'b0, 1'b0);
        do_op("div_startflush", 6'b011010, 0, 1'b0, 1'b1, 1'b0);
        do_op("mult", 6'b011000, 0, 1'b0, 1'b0, 1'b0);
        do_op("multu", 6'b011001, 0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset while RUN holds count 17.
        inSignal = 6'b011011;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        chk("prerst.stall", {5'b0, stall}, 6'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("rst.out", outSignal, 6'h00);
        chk("rst.stall", {5'b0, stall}, 6'h00);
        chk("rst.busy", {5'b0, busy}, 6'h00);
        chk("rst.we", {5'b0, hilo_we}, 6'h00);
        #2;
        rst = 1'b0;
        tick();
        do_op("divu_after_rst", 6'b011011, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 4))
                0: code = 6'b011010;
                1: code = 6'b011011;
                2: code = 6'b011000;
                3: code = 6'b011001;
                default: code = 6'($urandom_range(0, 63));
            endcase
            f = 0;
            if ($urandom_range(0, 2) == 0 && lat_of(code) > 1)
                f = $urandom_range(1, lat_of(code) - 1);
            do_op($sformatf("rnd%0d", i), code, f, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
